input_debouncer: RTL and testbench

//  Front-end conditioner for the board's 5 push-buttons and mode switch.

---
 rtl/input_debouncer.sv | 73 +++++++
 tb/tb_input_debouncer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Synchronises and debounces N_BTN button pads plus one switch pad, giving clean
// levels and one-cycle rising-edge pulses. Define SYNC_3FF_EN for a 3-flop synchroniser.
module input_debouncer #(
  parameter int N_BTN     = 5,
  parameter int CNT_W     = 16,
  parameter int DB_CYCLES = 50000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] buttons_raw,
  input  logic             switch_raw,
  output logic [N_BTN-1:0] buttons,
  output logic             switch,
  output logic [N_BTN-1:0] button_press,
  output logic             switch_rise
);

`ifdef SYNC_3FF_EN
  localparam int SYNC_DEPTH = 3;
`else
  localparam int SYNC_DEPTH = 2;
`endif

  // The switch rides along as the top channel so every channel shares one datapath.
  localparam int N_CH = N_BTN + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N_CH-1:0]  raw;
  logic [N_CH-1:0]  s;
  logic [N_CH-1:0]  sync_q [SYNC_DEPTH];
  logic [N_CH-1:0]  stable_q;
  logic [N_CH-1:0]  pulse_q;
  logic [CNT_W-1:0] cnt_q  [N_CH];

  assign raw = {switch_raw, buttons_raw};
  assign s   = sync_q[SYNC_DEPTH-1];

  // NOTE: state uses non-blocking assignments so every stage samples its
  // neighbour's pre-edge value; blocking here would collapse the synchroniser.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the counters and sync stages are plain flops, not RAM, so they
      // can and must be cleared by the loop below.
      for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= '0;
      for (int ch = 0; ch < N_CH; ch++) cnt_q[ch] <= '0;
      stable_q <= '0;
      pulse_q  <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_DEPTH; i++) sync_q[i] <= sync_q[i-1];

      for (int ch = 0; ch < N_CH; ch++) begin
        pulse_q[ch] <= 1'b0;
        if (s[ch] == stable_q[ch]) begin
          cnt_q[ch] <= '0;
        end else if (cnt_q[ch] == CNT_LAST) begin
          // New level survived the full window: adopt it, pulse only on a rise.
          stable_q[ch] <= s[ch];
          cnt_q[ch]    <= '0;
          pulse_q[ch]  <= s[ch];
        end else begin
          cnt_q[ch] <= cnt_q[ch] + CNT_W'(1);
        end
      end
    end
  end

  assign buttons      = stable_q[N_BTN-1:0];
  assign switch       = stable_q[N_BTN];
  assign button_press = pulse_q[N_BTN-1:0];
  assign switch_rise  = pulse_q[N_BTN];

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer with DB_CYCLES=4: directed cases plus random toggling,
// all compared against a sliding-window model of the debounce rule.
module tb_input_debouncer;

  localparam int N_BTN = 5;
  localparam int DB    = 4;
`ifdef SYNC_3FF_EN
  localparam int SD = 3;
`else
  localparam int SD = 2;
`endif
  localparam int LAT = DB + SD;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [N_BTN-1:0] buttons_raw = '0;
  logic             switch_raw = 1'b0;
  logic [N_BTN-1:0] buttons;
  logic             switch;
  logic [N_BTN-1:0] button_press;
  logic             switch_rise;

  input_debouncer #(.N_BTN(N_BTN), .CNT_W(16), .DB_CYCLES(DB)) dut (
    .clock(clock), .reset(reset), .buttons_raw(buttons_raw), .switch_raw(switch_raw),
    .buttons(buttons), .switch(switch), .button_press(button_press), .switch_rise(switch_rise)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: raw level applied before each edge since reset release.
  logic [5:0] raw_hist[$];
  logic [5:0] m_stable;
  logic [5:0] m_pulse;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Synchronised level the debouncer acts on at edge j (1-based since release).
  function automatic logic [5:0] s_at(input int j);
    if (j <= SD) return '0;
    return raw_hist[j-SD-1];
  endfunction

  // A channel adopts a new level once the last DB synchronised samples all show it.
  task automatic model_edge();
    int k = raw_hist.size();
    m_pulse = '0;
    for (int ch = 0; ch < 6; ch++) begin
      logic all_new = 1'b1;
      for (int j = k - DB + 1; j <= k; j++)
        if (s_at(j)[ch] == m_stable[ch]) all_new = 1'b0;
      if (all_new) begin
        m_stable[ch] = ~m_stable[ch];
        m_pulse[ch]  = m_stable[ch];
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {2'b0, switch_rise, button_press, switch}, 8'h00);
    check(tag, {3'b0, buttons}, 8'h00);
  endtask

  task automatic step(input logic [5:0] raw);
    buttons_raw = raw[4:0];
    switch_raw  = raw[5];
    raw_hist.push_back(raw);
    @(posedge clock);
    model_edge();
    #1;
    check("buttons",      {3'b0, buttons},      {3'b0, m_stable[4:0]});
    check("press",        {3'b0, button_press}, {3'b0, m_pulse[4:0]});
    check("switch",       {7'b0, switch},       {7'b0, m_stable[5]});
    check("switch_rise",  {7'b0, switch_rise},  {7'b0, m_pulse[5]});
  endtask

  // Called 1 time unit after a rising edge; asserts reset asynchronously mid-cycle.
  task automatic do_reset(input int cycles, input logic [5:0] raw);
    buttons_raw = raw[4:0];
    switch_raw  = raw[5];
    reset = 1'b0;
    #1 check_all_zero("reset_async");
    repeat (cycles) begin
      @(posedge clock);
      #1 check_all_zero("reset_held");
    end
    @(negedge clock);
    reset = 1'b1;
    raw_hist.delete();
    m_stable = '0;
    m_pulse  = '0;
  endtask

  initial begin
    logic [5:0] cur;
    m_stable = '0;
    m_pulse  = '0;

    // Test 1: all pads pressed through reset, then held.
    @(posedge clock); #1;
    do_reset(3, 6'h3F);
    for (int e = 1; e <= LAT + 1; e++) begin
      step(6'h3F);
      if (e == 1)       check("t1_first_edge", {3'b0, buttons}, 8'h00);
      if (e == LAT - 1) check("t1_before", {3'b0, buttons}, 8'h00);
      if (e == LAT)     check("t1_press", {3'b0, button_press}, 8'h1F);
      if (e == LAT)     check("t1_levels", {3'b0, buttons}, 8'h1F);
      if (e == LAT + 1) check("t1_press_end", {3'b0, button_press}, 8'h00);
    end

    // Test 2: single button rises at edge 1.
    do_reset(2, 6'h00);
    for (int e = 1; e <= LAT + 2; e++) begin
      step(6'h04);
      if (e == LAT - 1) check("t2_early", {3'b0, buttons}, 8'h00);
      if (e == LAT)     check("t2_rise", {3'b0, buttons, button_press[2]}, {3'b0, 5'h04, 1'b1});
      if (e == LAT + 1) check("t2_press_end", {3'b0, button_press}, 8'h00);
    end

    // Test 3: 3-cycle glitch never propagates.
    do_reset(2, 6'h00);
    for (int e = 1; e <= 12; e++) step(e <= DB - 1 ? 6'h01 : 6'h00);
    check("t3_glitch", {3'b0, buttons}, 8'h00);

    // Test 4: switch on, then off; only the rise pulses.
    do_reset(2, 6'h00);
    for (int e = 1; e <= LAT + 2; e++) begin
      step(6'h20);
      if (e == LAT) check("t4_rise", {6'b0, switch, switch_rise}, 8'h03);
    end
    for (int e = 1; e <= LAT; e++) begin
      step(6'h00);
      if (e == LAT - 1) check("t4_hold", {6'b0, switch, switch_rise}, 8'h02);
      if (e == LAT)     check("t4_fall", {6'b0, switch, switch_rise}, 8'h00);
    end

    // Test 5: two buttons together.
    do_reset(2, 6'h00);
    for (int e = 1; e <= LAT + 1; e++) begin
      step(6'h12);
      if (e == LAT)     check("t5_press", {3'b0, button_press}, 8'h12);
      if (e == LAT + 1) check("t5_press_end", {3'b0, button_press}, 8'h00);
    end

    // Test 7: reset mid-count restarts the full latency from release.
    do_reset(2, 6'h00);
    for (int e = 1; e <= SD + 2; e++) step(6'h08);
    do_reset(2, 6'h08);
    for (int e = 1; e <= LAT + 1; e++) begin
      step(6'h08);
      if (e == LAT - 1) check("t7_early", {3'b0, buttons}, 8'h00);
      if (e == LAT)     check("t7_press", {3'b0, button_press}, 8'h08);
    end

    // Random toggling: each channel flips with ~1/5 chance per cycle, giving a
    // mix of short glitches and runs long enough to debounce.
    cur = 6'h00;
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < 6; ch++)
        if ($urandom_range(4, 0) == 0) cur[ch] = ~cur[ch];
      if ($urandom_range(299, 0) == 0) do_reset($urandom_range(3, 1), cur);
      step(cur);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
